pkt_prio_sched: RTL and testbench

- Consumer end of the packet prioritiser output stream. Accepts `(in_data, in_prior)` beats with no backpressure.
- Stores each beat in a per-priority FIFO and drains the FIFOs in strict priority order through a valid/ready output register.
- Priority 1 is the highest priority; priority `SLOT_SIZE-1` is the lowest. Priority 0 is never valid and is discarded.
- Beats are dropped and counted when a queue is full or the priority is out of range.

---
 rtl/pkt_prio_sched_if.sv | 24 ++
 rtl/pkt_prio_sched.sv | 129 ++++++++++++
 tb/tb_pkt_prio_sched.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_prio_sched_if.sv
// Input beat stream and output valid/ready stream of the priority scheduler.
// slave: scheduler side; master: producer/consumer side.
interface pkt_prio_sched_if #(
  parameter int DWIDTH      = 32,
  parameter int PRIOR_WIDTH = 6
);
  logic                   in_valid;
  logic [DWIDTH-1:0]      in_data;
  logic [PRIOR_WIDTH-1:0] in_prior;
  logic                   out_valid;
  logic                   out_ready;
  logic [DWIDTH-1:0]      out_data;
  logic [PRIOR_WIDTH-1:0] out_prior;

  modport slave (
    input  in_valid, in_data, in_prior, out_ready,
    output out_valid, out_data, out_prior
  );

  modport master (
    output in_valid, in_data, in_prior, out_ready,
    input  out_valid, out_data, out_prior
  );
endinterface

// File: rtl/pkt_prio_sched.sv
// Per-priority FIFOs drained in strict priority order (1 = highest).
// Ports: clk, rst (async high), bus (in beats / out stream), q_nonempty, drop counters.
module pkt_prio_sched #(
  parameter int DWIDTH      = 32,
  parameter int PRIOR_WIDTH = 6,
  parameter int SLOT_SIZE   = 8,
  parameter int QDEPTH      = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pkt_prio_sched_if.slave      bus,
  output logic [SLOT_SIZE-2:0] q_nonempty,
  output logic [CNT_WIDTH-1:0] drop_full_cnt,
  output logic [CNT_WIDTH-1:0] drop_prio_cnt
);
  localparam int NQ = SLOT_SIZE - 1;
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  logic [DWIDTH-1:0] mem_q [NQ][QDEPTH];
  logic [AW-1:0]     head_q [NQ];
  logic [AW-1:0]     head_d [NQ];
  logic [AW-1:0]     tail_q [NQ];
  logic [AW-1:0]     tail_d [NQ];
  logic [CW-1:0]     cnt_q  [NQ];
  logic [CW-1:0]     cnt_d  [NQ];

  logic [NQ-1:0] push, pop, nonempty_d, nonempty_q;
  logic          prio_ok, hit, hit_full, load, found;

  logic                   out_valid_q, out_valid_d;
  logic [DWIDTH-1:0]      out_data_q, out_data_d;
  logic [PRIOR_WIDTH-1:0] out_prior_q, out_prior_d;
  logic [CNT_WIDTH-1:0]   dfull_q, dfull_d;
  logic [CNT_WIDTH-1:0]   dprio_q, dprio_d;

  always_comb begin
    push        = '0;
    pop         = '0;
    nonempty_d  = '0;
    hit         = 1'b0;
    hit_full    = 1'b0;
    found       = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_prior_d = out_prior_q;
    dfull_d     = dfull_q;
    dprio_d     = dprio_q;

    prio_ok = (bus.in_prior != '0) &&
              (32'(bus.in_prior) < 32'(SLOT_SIZE));

    // Fullness is judged on the pre-edge count only.
    for (int k = 0; k < NQ; k++) begin
      hit = bus.in_valid && prio_ok &&
            (bus.in_prior == PRIOR_WIDTH'(k + 1));
      push[k] = hit && (cnt_q[k] != FULL);
      if (hit && (cnt_q[k] == FULL)) hit_full = 1'b1;
    end

    load = !out_valid_q || bus.out_ready;

    // Lowest index wins; freshly pushed beats are not yet counted.
    for (int k = 0; k < NQ; k++) begin
      if (load && !found && (cnt_q[k] != '0)) begin
        pop[k]      = 1'b1;
        found       = 1'b1;
        out_data_d  = mem_q[k][head_q[k]];
        out_prior_d = PRIOR_WIDTH'(k + 1);
      end
    end
    if (load) out_valid_d = found;

    for (int k = 0; k < NQ; k++) begin
      head_d[k]     = head_q[k] + AW'(pop[k]);
      tail_d[k]     = tail_q[k] + AW'(push[k]);
      cnt_d[k]      = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
      nonempty_d[k] = (cnt_d[k] != '0);
    end

    if (hit_full && (dfull_q != '1)) dfull_d = dfull_q + 1'b1;
    if (bus.in_valid && !prio_ok && (dprio_q != '1))
      dprio_d = dprio_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NQ; k++) begin
        head_q[k] <= '0;
        tail_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
      nonempty_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_prior_q <= '0;
      dfull_q     <= '0;
      dprio_q     <= '0;
    end else begin
      for (int k = 0; k < NQ; k++) begin
        head_q[k] <= head_d[k];
        tail_q[k] <= tail_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
      nonempty_q  <= nonempty_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_prior_q <= out_prior_d;
      dfull_q     <= dfull_d;
      dprio_q     <= dprio_d;
    end
  end

  // Storage needs no reset: counts gate every read.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NQ; k++) begin
      if (push[k]) mem_q[k][tail_q[k]] <= bus.in_data;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_prior  = out_prior_q;
  assign q_nonempty     = nonempty_q;
  assign drop_full_cnt  = dfull_q;
  assign drop_prio_cnt  = dprio_q;
endmodule

// File: tb/tb_pkt_prio_sched.sv
// Self-checking bench for pkt_prio_sched: table vectors,
// hand-written corner sequences and a randomized queue-model run.
module tb_pkt_prio_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] q_nonempty;
  logic [15:0] drop_full_cnt, drop_prio_cnt;

  int checks = 0;
  int errors = 0;

  pkt_prio_sched_if #(.DWIDTH(32), .PRIOR_WIDTH(6)) bus ();

  pkt_prio_sched dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .q_nonempty    (q_nonempty),
    .drop_full_cnt (drop_full_cnt),
    .drop_prio_cnt (drop_prio_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per priority plus output register.
  logic [31:0] mq [7][$];
  logic        m_valid;
  logic [31:0] m_data;
  logic [5:0]  m_prior;
  int          m_full, m_prio;

  task automatic model_reset();
    for (int k = 0; k < 7; k++) mq[k].delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_prior = '0;
    m_full  = 0;
    m_prio  = 0;
  endtask

  task automatic model_step(input logic v, input logic [5:0] p,
                            input logic [31:0] d, input logic r);
    int  sz [7];
    bit  got;
    for (int k = 0; k < 7; k++) sz[k] = mq[k].size();
    if (!m_valid || r) begin
      got = 0;
      for (int k = 0; k < 7; k++) begin
        if (!got && sz[k] > 0) begin
          got     = 1;
          m_data  = mq[k].pop_front();
          m_prior = 6'(k + 1);
        end
      end
      m_valid = got;
    end
    if (v) begin
      if (p == 0 || p >= 8) begin
        if (m_prio < 65535) m_prio++;
      end else if (sz[p-1] < 4) begin
        mq[p-1].push_back(d);
      end else begin
        if (m_full < 65535) m_full++;
      end
    end
  endtask

  function automatic logic [6:0] model_ne();
    logic [6:0] ne;
    for (int k = 0; k < 7; k++) ne[k] = (mq[k].size() > 0);
    return ne;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] p,
                       input logic [31:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_prior  = p;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  // Apply inputs, clock one edge, step model, settle.
  task automatic cyc(input logic v, input logic [5:0] p,
                     input logic [31:0] d, input logic r);
    drive(v, p, d, r);
    @(posedge clk);
    model_step(v, p, d, r);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst = 1'b1;
    #7;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  typedef struct {
    logic        v;
    logic [5:0]  p;
    logic [31:0] d;
    logic        r;
    logic        ev;
    logic [31:0] ed;
    logic [5:0]  ep;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [31:0] prev_d;

    // Blocker beat parks in the output reg; five beats queue behind it.
    tbl[0]  = '{1, 1, 32'h0B, 0, 0, 32'h0,  0};
    tbl[1]  = '{1, 5, 32'h01, 0, 1, 32'h0B, 1};
    tbl[2]  = '{1, 2, 32'h02, 0, 1, 32'h0B, 1};
    tbl[3]  = '{1, 5, 32'h03, 0, 1, 32'h0B, 1};
    tbl[4]  = '{1, 7, 32'h04, 0, 1, 32'h0B, 1};
    tbl[5]  = '{1, 2, 32'h05, 0, 1, 32'h0B, 1};
    tbl[6]  = '{0, 0, 32'h00, 1, 1, 32'h02, 2};
    tbl[7]  = '{0, 0, 32'h00, 1, 1, 32'h05, 2};
    tbl[8]  = '{0, 0, 32'h00, 1, 1, 32'h01, 5};
    tbl[9]  = '{0, 0, 32'h00, 1, 1, 32'h03, 5};
    tbl[10] = '{0, 0, 32'h00, 1, 1, 32'h04, 7};
    tbl[11] = '{0, 0, 32'h00, 1, 0, 32'h04, 7};

    do_reset();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_prior", bus.out_prior, 0);
    chk("rst_ne", q_nonempty, 0);
    chk("rst_cnts", {drop_full_cnt, drop_prio_cnt}, 0);

    // Single beat latency.
    cyc(1, 3, 32'hA5A5_0001, 1);
    chk("single_e0_valid", bus.out_valid, 0);
    chk("single_e0_ne", q_nonempty, 7'b0000100);
    cyc(0, 0, 0, 1);
    chk("single_e1_valid", bus.out_valid, 1);
    chk("single_e1_data", bus.out_data, 32'hA5A5_0001);
    chk("single_e1_prior", bus.out_prior, 3);
    chk("single_e1_ne", q_nonempty, 0);
    cyc(0, 0, 0, 1);
    chk("single_e2_valid", bus.out_valid, 0);

    // Strict priority / FIFO order table.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].v, tbl[i].p, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i), bus.out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_data", i), bus.out_data, tbl[i].ed);
      chk($sformatf("tbl%0d_prior", i), bus.out_prior, tbl[i].ep);
    end

    // Full-queue drop at priority 1 with out_ready low.
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1, 1, 32'h100 + 32'(i), 0);
    chk("full_drop_cnt", drop_full_cnt, 1);
    chk("full_out_data", bus.out_data, 32'h100);
    chk("full_ne", q_nonempty, 7'b0000001);
    drive(0, 0, 0, 1);
    for (int i = 1; i < 5; i++) begin
      cyc(0, 0, 0, 1);
      chk($sformatf("full_drain%0d", i), bus.out_data, 32'h100 + 32'(i));
    end
    cyc(0, 0, 0, 1);
    chk("full_drain_empty", bus.out_valid, 0);

    // Bad priorities.
    do_reset();
    cyc(1, 0, 32'h1, 1);
    chk("bad0_valid", bus.out_valid, 0);
    cyc(1, 8, 32'h2, 1);
    chk("bad8_valid", bus.out_valid, 0);
    cyc(1, 9, 32'h3, 1);
    chk("bad9_valid", bus.out_valid, 0);
    cyc(0, 0, 0, 1);
    chk("bad_cnt", drop_prio_cnt, 3);
    chk("bad_ne", q_nonempty, 0);
    chk("bad_valid", bus.out_valid, 0);

    // Async reset mid-cycle with beats queued and held.
    do_reset();
    cyc(1, 0, 32'h9, 0);
    for (int i = 0; i < 4; i++) cyc(1, 2, 32'h20 + 32'(i), 0);
    chk("pre_rst_valid", bus.out_valid, 1);
    chk("pre_rst_ne", q_nonempty, 7'b0000010);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_ne", q_nonempty, 0);
    chk("async_rst_cnt", drop_prio_cnt, 0);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    chk("post_rst_valid", bus.out_valid, 0);

    // Randomized run against the queue model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        v, r;
      logic [5:0]  p;
      logic [31:0] d;
      logic        held;
      v = ($urandom_range(0, 9) < 7);
      p = 6'($urandom_range(0, 9));
      d = $urandom;
      r = ($urandom_range(0, 9) < 5);
      held   = bus.out_valid && !r;
      prev_d = bus.out_data;
      cyc(v, p, d, r);
      chk("rnd_valid", bus.out_valid, m_valid);
      if (m_valid) begin
        chk("rnd_data", bus.out_data, m_data);
        chk("rnd_prior", bus.out_prior, m_prior);
      end
      if (held) chk("rnd_hold", bus.out_data, prev_d);
      chk("rnd_ne", q_nonempty, model_ne());
      chk("rnd_full", drop_full_cnt, 16'(m_full));
      chk("rnd_prio", drop_prio_cnt, 16'(m_prio));
    end

    // Counter saturation: queue 1 full, output held, keep writing.
    do_reset();
    drive(1, 1, 32'h55, 0);
    repeat (65539) @(posedge clk);
    #1;
    chk("sat_mid", drop_full_cnt, 16'd65534);
    repeat (7) @(posedge clk);
    #1;
    chk("sat_top", drop_full_cnt, 16'hFFFF);
    drive(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
